// File: rtl/dmb_pkg.sv
// Shared types and helpers for the debug mailbox byte packer and FIFO read side.
package dmb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StPush = 2'd2
    } dmb_state_e;

    localparam int unsigned DMB_DATA_WIDTH = 32;
    localparam int unsigned BYTES_PER_WORD = DMB_DATA_WIDTH / 8;

    // Lane count must be able to represent a full word, hence the extra bit.
    function automatic int unsigned lane_cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/dmb_idle_timer.sv
// Idle down-counter: reloads on clear, counts down while enabled, flags expiry at zero.
module dmb_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] LOAD = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero reload value means the timeout is disabled, not instantly expired.
    assign expire_o = (TIMEOUT_CYCLES != 0) && (cnt_q == '0);

endmodule

// File: rtl/dmb_byte_packer.sv
// Packs a valid/ready byte stream little-endian into words and pushes them into the
// mailbox FIFO over wrReq/wrAck; partial words go out on flush or idle timeout.
module dmb_byte_packer
    import dmb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [7:0]  PAD_BYTE       = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            byte_valid_i,
    output logic                            byte_ready_o,
    input  logic [7:0]                      byte_data_i,
    input  logic                            flush_i,
    output logic                            wr_req_o,
    input  logic                            wr_ack_i,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    output logic [$clog2(DATA_WIDTH/8):0]   lane_cnt_o,
    output logic [CNT_W-1:0]                word_cnt_o
);

    localparam int unsigned N   = DATA_WIDTH / 8;
    localparam int unsigned LCW = lane_cnt_width(N);

    dmb_state_e            state_q, state_d;
    logic [LCW-1:0]        lanes_q, lanes_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;

    logic           accept;
    logic           expire;
    logic           active;
    logic [LCW-1:0] base_cnt;
    logic [LCW-1:0] n_new;

    assign byte_ready_o = rst_i ? 1'b0 : ((state_q == StPush) ? wr_ack_i : 1'b1);
    assign accept       = byte_valid_i & byte_ready_o;

    dmb_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (accept || (state_q != StFill)),
        .en_i     ((state_q == StFill) && !accept),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        lanes_d    = lanes_q;
        data_d     = data_q;
        word_cnt_d = word_cnt_q;
        base_cnt   = lanes_q;
        active     = 1'b1;
        n_new      = '0;

        // A pending word either completes this cycle (freeing the register) or holds everything.
        if (state_q == StPush) begin
            if (wr_ack_i) begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
                base_cnt   = '0;
            end else begin
                active = 1'b0;
            end
        end

        if (active) begin
            n_new = base_cnt + LCW'(accept);
            for (int k = 0; k < N; k++) begin
                if (accept && (LCW'(k) == base_cnt)) begin
                    data_d[8*k +: 8] = byte_data_i;
                end
            end
            lanes_d = n_new;
            if (n_new == LCW'(N)) begin
                state_d = StPush;
            end else if ((n_new != '0) && (flush_i || expire)) begin
                for (int k = 0; k < N; k++) begin
                    if (LCW'(k) >= n_new) begin
                        data_d[8*k +: 8] = PAD_BYTE;
                    end
                end
                state_d = StPush;
            end else if (n_new != '0) begin
                state_d = StFill;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            lanes_q    <= '0;
            data_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lanes_q    <= lanes_d;
            data_q     <= data_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign wr_req_o   = (state_q == StPush);
    assign wdata_o    = data_q;
    assign lane_cnt_o = lanes_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_dmb_byte_packer.sv
// Directed self-checking bench for dmb_byte_packer with default parameters.
module tb_dmb_byte_packer;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        flush;
    logic        wr_req;
    logic        wr_ack;
    logic [31:0] wdata;
    logic [2:0]  lane_cnt;
    logic [15:0] word_cnt;

    int n_cmp = 0;
    int n_err = 0;

    dmb_byte_packer #(
        .DATA_WIDTH     (32),
        .PAD_BYTE       (8'h00),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .byte_data_i  (byte_data),
        .flush_i      (flush),
        .wr_req_o     (wr_req),
        .wr_ack_i     (wr_ack),
        .wdata_o      (wdata),
        .lane_cnt_o   (lane_cnt),
        .word_cnt_o   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    logic [7:0] seq8 [8];

    initial begin
        seq8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; flush = 1'b0; wr_ack = 1'b1;
        #1;
        check("rst_ready_low", byte_ready, 0);
        tick(); tick();
        check("rst_ready_low_held", byte_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_wr_req", wr_req, 0);
        check("rst_lane_cnt", lane_cnt, 0);
        check("rst_wdata", wdata, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("idle_ready", byte_ready, 1);

        // Single full word
        for (int i = 0; i < 4; i++) send_byte(seq8[i]);
        check("w1_req", wr_req, 1);
        check("w1_data", wdata, 32'h44332211);
        check("w1_lanes", lane_cnt, 4);
        tick();
        check("w1_req_drop", wr_req, 0);
        check("w1_word_cnt", word_cnt, 1);
        check("w1_lanes_idle", lane_cnt, 0);

        // Eight bytes back to back, ready must never drop
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1;
            byte_data  = seq8[i];
            #1;
            check("b2b_ready", byte_ready, 1);
            if (i == 4) check("b2b_first_word", wdata, 32'h44332211);
            if (i == 4) check("b2b_first_req", wr_req, 1);
            tick();
        end
        byte_valid = 1'b0;
        check("b2b_second_req", wr_req, 1);
        check("b2b_second_word", wdata, 32'h88776655);
        check("b2b_cnt_mid", word_cnt, 2);
        tick();
        check("b2b_cnt_end", word_cnt, 3);

        // Explicit flush of a partial word
        send_byte(8'hAA);
        send_byte(8'hBB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_req", wr_req, 1);
        check("flush_data", wdata, 32'h0000BBAA);
        check("flush_lanes", lane_cnt, 2);
        tick();
        check("flush_word_cnt", word_cnt, 4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("idle_flush_no_req", wr_req, 0);
        check("idle_flush_lanes", lane_cnt, 0);
        tick();
        check("idle_flush_cnt", word_cnt, 4);

        // Backpressure: word held, byte refused, flush ignored
        wr_ack = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        for (int i = 0; i < 5; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'h99;
            flush      = 1'b1;
            #1;
            check("bp_ready", byte_ready, 0);
            check("bp_req", wr_req, 1);
            check("bp_data", wdata, 32'h04030201);
            check("bp_lanes", lane_cnt, 4);
            tick();
        end
        byte_valid = 1'b0; flush = 1'b0;
        check("bp_cnt_held", word_cnt, 4);
        wr_ack = 1'b1;
        tick();
        check("bp_release_req", wr_req, 0);
        check("bp_release_cnt", word_cnt, 5);

        // Idle timeout auto-flush
        send_byte(8'h5A);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("to_no_early_push", wr_req, 0);
        end
        tick();
        check("to_req", wr_req, 1);
        check("to_data", wdata, 32'h0000005A);
        check("to_lanes", lane_cnt, 1);
        tick();
        check("to_cnt", word_cnt, 6);

        // A byte at idle cycle 15 restarts the timer
        send_byte(8'h5B);
        for (int i = 1; i <= 15; i++) tick();
        check("tr_no_push_15", wr_req, 0);
        send_byte(8'hC3);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("tr_no_early_push", wr_req, 0);
        end
        tick();
        check("tr_req", wr_req, 1);
        check("tr_data", wdata, 32'h0000C35B);
        check("tr_lanes", lane_cnt, 2);
        tick();
        check("tr_cnt", word_cnt, 7);

        // Reset with a partial word pending
        wr_ack = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        byte_valid = 1'b1; byte_data = 8'h03; flush = 1'b1;
        tick();
        byte_valid = 1'b0; flush = 1'b0;
        check("mr_pending_req", wr_req, 1);
        check("mr_pending_lanes", lane_cnt, 3);
        wr_ack = 1'b1; byte_valid = 1'b1; byte_data = 8'h77; rst = 1'b1;
        #1;
        check("mr_ready_in_rst", byte_ready, 0);
        tick();
        check("mr_req", wr_req, 0);
        check("mr_lanes", lane_cnt, 0);
        check("mr_word_cnt", word_cnt, 0);
        check("mr_wdata", wdata, 0);
        rst = 1'b0; byte_valid = 1'b0;
        tick();
        check("mr_after_req", wr_req, 0);
        check("mr_after_cnt", word_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
